// File: rtl/fc_layer_sequencer.sv
// Sequences one fully connected layer pass: operand fetch, result capture,
// optional backprop wait, and a watchdog that aborts a stalled datapath.
module fc_layer_sequencer #(
  parameter int INPUT_SIZE  = 120,
  parameter int OUTPUT_SIZE = 10,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT     = 4096,
  localparam int IAW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
  localparam int OAW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1,
  localparam int CW  = $clog2(OUTPUT_SIZE + 1),
  localparam int WW  = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              train,
  input  logic [DATA_W-1:0] lr_in,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              in_rd_en,
  output logic [IAW-1:0]    in_rd_addr,
  input  logic [DATA_W-1:0] in_rd_data,
  output logic              err_rd_en,
  output logic [OAW-1:0]    err_rd_addr,
  input  logic [DATA_W-1:0] err_rd_data,
  output logic              fc_enable,
  input  logic [IAW-1:0]    fc_input_addr,
  output logic [DATA_W-1:0] fc_input_data,
  output logic              fc_input_valid,
  input  logic [DATA_W-1:0] fc_output_data,
  input  logic [OAW-1:0]    fc_output_addr,
  input  logic              fc_output_valid,
  input  logic              fc_done,
  input  logic              fc_backprop_done,
  output logic [DATA_W-1:0] fc_output_error,
  output logic [DATA_W-1:0] fc_learning_rate,
  output logic              out_wr_en,
  output logic [OAW-1:0]    out_wr_addr,
  output logic [DATA_W-1:0] out_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_KICK, S_FETCH, S_PRESENT,
    S_GAP, S_FINISH, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              train_q, train_d;
  logic [DATA_W-1:0] lr_q, lr_d;
  logic              fc_en_q, fc_en_d;
  logic              rd_en_q, rd_en_d;
  logic [IAW-1:0]    rd_addr_q, rd_addr_d;
  logic              in_vld_q, in_vld_d;
  logic              wr_en_q, wr_en_d;
  logic [OAW-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic              fdone_q, fdone_d;
  logic              bdone_q, bdone_d;
  logic              err_vld_q, err_vld_d;
  logic              fdone_now, bdone_now, act;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tmo_d     = tmo_q;
    train_d   = train_q;
    lr_d      = lr_q;
    fc_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    in_vld_d  = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    err_vld_d = busy_q & train_q;

    fdone_now = fdone_q | (busy_q & fc_done);
    bdone_now = bdone_q | (busy_q & fc_backprop_done);
    fdone_d   = fdone_now;
    bdone_d   = bdone_now;

    act  = in_vld_q | wr_en_q | fc_done | fc_backprop_done;
    wd_d = '0;
    if (busy_q && !act) wd_d = wd_q + WW'(1);

    // Each neuron is written once, strictly in index order.
    if (busy_q && fc_output_valid &&
        CW'(fc_output_addr) == cnt_q &&
        cnt_q < CW'(OUTPUT_SIZE)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = fc_output_addr;
      wr_data_d = fc_output_data;
      cnt_d     = cnt_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          train_d = train;
          lr_d    = lr_in;
          tmo_d   = 1'b0;
          cnt_d   = '0;
          fdone_d = 1'b0;
          bdone_d = 1'b0;
          busy_d  = 1'b1;
          fc_en_d = 1'b1;
          state_d = S_KICK;
        end
      end
      S_KICK: begin
        rd_en_d   = 1'b1;
        rd_addr_d = fc_input_addr;
        state_d   = S_FETCH;
      end
      S_FETCH: begin
        in_vld_d = 1'b1;
        state_d  = S_PRESENT;
      end
      S_PRESENT: state_d = S_GAP;
      S_GAP: begin
        if (fdone_now) begin
          state_d = S_FINISH;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = fc_input_addr;
          state_d   = S_FETCH;
        end
      end
      S_FINISH: begin
        if (fdone_now && (!train_q || bdone_now)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (busy_q && state_q != S_DONE &&
        wd_d == WW'(TIMEOUT - 1)) begin
      tmo_d    = 1'b1;
      done_d   = 1'b1;
      fc_en_d  = 1'b0;
      rd_en_d  = 1'b0;
      in_vld_d = 1'b0;
      wr_en_d  = 1'b0;
      cnt_d    = cnt_q;
      state_d  = S_DONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      train_q   <= 1'b0;
      lr_q      <= '0;
      fc_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      in_vld_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      fdone_q   <= 1'b0;
      bdone_q   <= 1'b0;
      err_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      train_q   <= train_d;
      lr_q      <= lr_d;
      fc_en_q   <= fc_en_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      in_vld_q  <= in_vld_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      fdone_q   <= fdone_d;
      bdone_q   <= bdone_d;
      err_vld_q <= err_vld_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign timeout_err      = tmo_q;
  assign fc_enable        = fc_en_q;
  assign in_rd_en         = rd_en_q;
  assign in_rd_addr       = rd_addr_q;
  assign fc_input_valid   = in_vld_q;
  // RAM data arrives one cycle after the read, i.e. while the strobe is up.
  assign fc_input_data    = in_vld_q ? in_rd_data : '0;
  assign err_rd_en        = busy_q & train_q;
  assign err_rd_addr      = err_rd_en ? fc_output_addr : '0;
  assign fc_output_error  = err_vld_q ? err_rd_data : '0;
  assign fc_learning_rate = lr_q;
  assign out_wr_en        = wr_en_q;
  assign out_wr_addr      = wr_addr_q;
  assign out_wr_data      = wr_data_q;

endmodule
